// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO. Frames are start, DATA_BITS LSB first,
// optional parity and STOP_BITS stop bits. Back-to-back frames are sent without an idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          parity_odd,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [AW:0]       FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   serial_q, serial_d;

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   load;
    logic                   bit_done;
    logic [DATA_BITS-1:0]   head;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign push       = tx_valid && !full;
    assign head       = mem_q[rd_ptr_q];
    assign bit_done   = (cnt_q == BIT_LAST);

    assign tx_ready   = !full;
    assign fifo_count = count_q;
    assign serial_out = serial_q;
    assign busy       = (state_q != IDLE);

    // Frame sequencing; a load (pop + latch) happens from IDLE or at the end of the last stop bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        if (!empty) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (load) begin
            shift_d  = head;
            parity_d = (^head) ^ parity_odd;
        end
    end

    assign pop = load;

    // Line level is registered from the next state so it changes exactly on bit boundaries.
    always_comb begin
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1+parity instance and a 7-bit, no parity, 2-stop instance.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_odd;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    logic [6:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       parity_odd2;
    logic       serial_out2;
    logic       busy2;
    logic [2:0] fifo_count2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  fill_words  [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    logic [15:0] fill_frames [5] = '{16'h742, 16'h564, 16'h586, 16'h5A8, 16'h7CA};

    uart_tx_fifo #(
        .DATA_BITS   (8),
        .PARITY_EN   (1),
        .STOP_BITS   (1),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .parity_odd(parity_odd),
        .serial_out(serial_out),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    uart_tx_fifo #(
        .DATA_BITS   (7),
        .PARITY_EN   (0),
        .STOP_BITS   (2),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data2),
        .tx_valid  (tx_valid2),
        .tx_ready  (tx_ready2),
        .parity_odd(parity_odd2),
        .serial_out(serial_out2),
        .busy      (busy2),
        .fifo_count(fifo_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ser_of(input bit which);
        return which ? serial_out2 : serial_out;
    endfunction

    function automatic logic busy_of(input bit which);
        return which ? busy2 : busy;
    endfunction

    task automatic push(input logic [7:0] d);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // frame[0] is the start bit; every bit must hold for exactly CPB samples.
    task automatic expect_frame(input string tag, input bit which, input logic [15:0] frame,
                                input int nbits, input int max_wait);
        bit found = 1'b0;
        for (int i = 0; i < max_wait && !found; i++) begin
            @(negedge clk);
            if (ser_of(which) == 1'b0) found = 1'b1;
        end
        check({tag, " start"}, 32'(found), 32'd1);
        if (found) begin
            for (int b = 0; b < nbits; b++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    check($sformatf("%s bit%0d", tag, b), 32'(ser_of(which)), 32'(frame[b]));
                    if (b == nbits - 1 && c == CPB - 1)
                        check({tag, " busy_end"}, 32'(busy_of(which)), 32'd1);
                end
            end
        end
    endtask

    task automatic expect_idle(input string tag, input bit which);
        @(negedge clk);
        check({tag, " idle_serial"}, 32'(ser_of(which)), 32'd1);
        check({tag, " idle_busy"}, 32'(busy_of(which)), 32'd0);
    endtask

    initial begin
        bit found;
        rst         = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = '0;
        parity_odd  = 1'b1;
        tx_valid2   = 1'b0;
        tx_data2    = '0;
        parity_odd2 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst serial", 32'(serial_out), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", 32'(fifo_count), 32'd0);
        check("rst ready", 32'(tx_ready), 32'd1);
        check("rst serial2", 32'(serial_out2), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Odd parity frame; inputs change after load and must not disturb it.
        push(8'h55);
        @(posedge clk);
        #1;
        tx_data    = 8'hFF;
        parity_odd = 1'b0;
        expect_frame("f55", 1'b0, 16'h6AA, 11, 10);
        expect_idle("f55", 1'b0);

        push(8'h07);
        expect_frame("f07", 1'b0, 16'h60E, 11, 10);
        expect_idle("f07", 1'b0);
        push(8'h03);
        expect_frame("f03", 1'b0, 16'h406, 11, 10);
        expect_idle("f03", 1'b0);

        // Overfill while idle, then five contiguous frames.
        fork
            begin
                @(posedge clk);
                #1;
                tx_valid = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    tx_data = fill_words[i];
                    @(negedge clk);
                    if (i == 2) begin
                        check("pushpop count", 32'(fifo_count), 32'd1);
                        check("pushpop busy", 32'(busy), 32'd1);
                    end
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
                @(negedge clk);
                check("fill count", 32'(fifo_count), 32'd4);
                check("fill ready", 32'(tx_ready), 32'd0);
            end
            begin
                expect_frame("fill0", 1'b0, fill_frames[0], 11, 10);
                for (int k = 1; k < 5; k++)
                    expect_frame($sformatf("fill%0d", k), 1'b0, fill_frames[k], 11, 1);
            end
        join
        expect_idle("fill", 1'b0);
        check("fill drained", 32'(fifo_count), 32'd0);

        // Reset during data bit 3 with another word queued.
        push(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (serial_out == 1'b0) found = 1'b1;
        end
        check("mid start", 32'(found), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid bit3", 32'(serial_out), 32'd1);
        check("mid count", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst serial", 32'(serial_out), 32'd1);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst count", 32'(fifo_count), 32'd0);
        check("mid rst ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post rst serial", 32'(serial_out), 32'd1);
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst count", 32'(fifo_count), 32'd0);
        parity_odd = 1'b1;
        push(8'h81);
        expect_frame("f81", 1'b0, 16'h702, 11, 10);
        expect_idle("f81", 1'b0);

        // 7 data bits, no parity, two stop bits.
        @(posedge clk);
        #1;
        tx_valid2 = 1'b1;
        tx_data2  = 7'h5A;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        expect_frame("cfg2", 1'b1, 16'h3B4, 10, 10);
        expect_idle("cfg2", 1'b1);
        check("cfg2 count", 32'(fifo_count2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
